spw_status_pio: RTL

//  Parametrised Avalon-MM input port for SpaceWire link-status bits (state, errors, flags).

---
 rtl/spw_status_pio.sv | 114 +++++++++++
 1 files changed

// File: rtl/spw_status_pio.sv
// Avalon-MM input port for SpaceWire link-status bits: synchronizer, edge capture,
// per-bit interrupt mask and a level IRQ.
module spw_status_pio #(
   parameter int WIDTH       = 3,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   input  logic [WIDTH-1:0]  in_port,
   output logic [31:0]       readdata,
   output logic              irq
);

   localparam int PRIME_MAX = SYNC_STAGES + 1;
   localparam int PW        = $clog2(PRIME_MAX + 1);
   localparam logic [PW-1:0] PRIME_TOP = PW'(PRIME_MAX);

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_d [SYNC_STAGES];
   logic [WIDTH-1:0] data_dly_q, data_dly_d;
   logic [WIDTH-1:0] irqmask_q, irqmask_d;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [PW-1:0]    prime_cnt_q, prime_cnt_d;
   logic [31:0]      readdata_q, readdata_d;

   logic [WIDTH-1:0] data_sync;
   logic [WIDTH-1:0] rise, fall, edge_det, clr;
   logic             primed, wr_en;
   logic             unused_wdata;

   assign data_sync = sync_q[SYNC_STAGES-1];
   assign primed    = (prime_cnt_q == PRIME_TOP);
   assign wr_en     = chipselect & ~write_n;
   assign rise      = data_sync & ~data_dly_q;
   assign fall      = ~data_sync & data_dly_q;

   // Edge polarity is fixed at build time, so only one detector survives synthesis.
   generate
      if (EDGE_TYPE == 1) begin : g_rise
         assign edge_det = rise;
      end else if (EDGE_TYPE == 2) begin : g_fall
         assign edge_det = fall;
      end else begin : g_any
         assign edge_det = rise | fall;
      end
   endgenerate

   // Upper writedata bits are architecturally ignored when WIDTH < 32.
   assign unused_wdata = &{1'b0, writedata};

   always_comb begin
      sync_d[0] = in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      data_dly_d  = data_sync;
      prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + 1'b1;

      clr = '0;
      if (wr_en && (address == ADDR_EDGECAP)) begin
         clr = writedata[WIDTH-1:0];
      end
      // A fresh edge on a bit being cleared keeps that bit set.
      edgecap_d = (edgecap_q & ~clr) | (edge_det & {WIDTH{primed}});

      irqmask_d = irqmask_q;
      if (wr_en && (address == ADDR_IRQMASK)) begin
         irqmask_d = writedata[WIDTH-1:0];
      end

      readdata_d = 32'd0;
      case (address)
         ADDR_DATA:    readdata_d = 32'(data_sync);
         ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
         ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
         default:      readdata_d = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         data_dly_q  <= '0;
         prime_cnt_q <= '0;
         edgecap_q   <= '0;
         irqmask_q   <= '0;
         readdata_q  <= 32'd0;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
         data_dly_q  <= data_dly_d;
         prime_cnt_q <= prime_cnt_d;
         edgecap_q   <= edgecap_d;
         irqmask_q   <= irqmask_d;
         readdata_q  <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(edgecap_q & irqmask_q);

endmodule
